// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: holds the fetch PC, drives IMEM requests and applies branch/jump redirects.
// Define BRANCH_DELAY_SLOT_EN to keep the instruction fetched in the redirect cycle (MIPS delay slot).
module f_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_con_ifbranch,
    input  logic        i_con_jump,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic        i_imem_ready,
    output logic        o_imem_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_fetch_valid,
    output logic        o_flush_d,
    output logic        o_misalign,
    output logic [1:0]  o_state
);

    // IMEM handshake: a request is presented while o_imem_req=1 and completes in any cycle
    // where i_imem_ready=1; o_pc never changes while a request is presented but not accepted.
    typedef enum logic [1:0] {BOOT, FETCH, WAIT, REDIR} state_e;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic KEEP_SLOT = 1'b1;
`else
    localparam logic KEEP_SLOT = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] raw_tgt;
    logic [31:0] tgt;

    assign redirect = (i_con_ifbranch | i_con_jump) & ~i_stall & (state_q != BOOT);
    assign raw_tgt  = i_con_jump ? i_jump_target : i_branch_target;
    assign tgt      = {raw_tgt[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        misalign_d    = misalign_q | (redirect & (raw_tgt[1:0] != 2'b00));
        o_fetch_valid = 1'b0;
        o_flush_d     = 1'b0;
        if (!i_stall) begin
            case (state_q)
                BOOT: state_d = FETCH;
                FETCH, WAIT: begin
                    if (redirect) begin
                        o_flush_d     = ~KEEP_SLOT;
                        o_fetch_valid = i_imem_ready & KEEP_SLOT;
                        if (i_imem_ready) begin
                            pc_d    = tgt;
                            state_d = FETCH;
                        end else begin
                            tgt_d   = tgt;
                            state_d = REDIR;
                        end
                    end else if (i_imem_ready) begin
                        o_fetch_valid = 1'b1;
                        pc_d          = pc_q + PC_STEP;
                        state_d       = FETCH;
                    end else begin
                        state_d = WAIT;
                    end
                end
                REDIR: begin
                    // The returning instruction belongs to the pre-redirect stream.
                    o_flush_d = ~KEEP_SLOT & (redirect | i_imem_ready);
                    if (i_imem_ready) begin
                        o_fetch_valid = KEEP_SLOT;
                        pc_d          = redirect ? tgt : tgt_q;
                        state_d       = FETCH;
                    end else if (redirect) begin
                        tgt_d = tgt;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_imem_req = (state_q != BOOT);
    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_q + PC_STEP;
    assign o_misalign = misalign_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Bench for f_pc_sequencer: directed vectors, fetch-PC scoreboard, directed control checks.
module tb_f_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        jmp;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        ready;
    logic        req;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fvalid;
    logic        flush;
    logic        misalign;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    f_pc_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_con_ifbranch(br), .i_con_jump(jmp),
        .i_branch_target(br_tgt), .i_jump_target(j_tgt),
        .i_imem_ready(ready), .o_imem_req(req), .o_pc(pc), .o_pc_plus4(pc4),
        .o_fetch_valid(fvalid), .o_flush_d(flush), .o_misalign(misalign),
        .o_state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance one clock; inputs change 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic no_redirect();
        br = 1'b0; jmp = 1'b0; br_tgt = 32'd0; j_tgt = 32'd0;
    endtask

    // scoreboard monitor: every accepted fetch must match the next expected PC
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: got pc %h expected no fetch", pc);
            end else begin
                chk("fetch_pc", pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; ready = 1'b1;
        no_redirect();
        cyc(); cyc();
        settle();
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_valid", {31'd0, fvalid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        // BOOT then sequential fetch
        cyc();
        rst_n = 1'b1;
        settle();
        chk("boot_req", {31'd0, req}, 32'd0);
        chk("boot_pc", pc, 32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0008);
        cyc(); settle();
        chk("first_fetch_req", {31'd0, req}, 32'd1);
        chk("pc_plus4", pc4, 32'hBFC0_0004);
        cyc(); cyc();

        // jump to 0x10 from 0xBFC0000C
        cyc();
        jmp = 1'b1; j_tgt = 32'h10;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'hBFC0_000C);
`endif
        settle();
`ifdef BRANCH_DELAY_SLOT_EN
        chk("jmp_flush", {31'd0, flush}, 32'd0);
`else
        chk("jmp_flush", {31'd0, flush}, 32'd1);
        chk("jmp_valid", {31'd0, fvalid}, 32'd0);
`endif

        // ready low for three cycles at 0x10
        cyc();
        no_redirect();
        ready = 1'b0;
        settle();
        chk("wait0_pc", pc, 32'h10);
        chk("wait0_valid", {31'd0, fvalid}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            cyc(); settle();
            chk("wait_pc", pc, 32'h10);
            chk("wait_req", {31'd0, req}, 32'd1);
            chk("wait_valid", {31'd0, fvalid}, 32'd0);
        end
        cyc();
        ready = 1'b1;
        for (int a = 32'h10; a <= 32'h1C; a += 4) begin
            exp_q.push_back(a);
            if (a != 32'h1C) cyc();
        end

        // branch to 0x40 at pc 0x20
        cyc();
        br = 1'b1; br_tgt = 32'h40;
        settle();
        chk("br_pc", pc, 32'h20);
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'h20);
        chk("br_valid", {31'd0, fvalid}, 32'd1);
        chk("br_flush", {31'd0, flush}, 32'd0);
`else
        chk("br_valid", {31'd0, fvalid}, 32'd0);
        chk("br_flush", {31'd0, flush}, 32'd1);
`endif
        cyc();
        no_redirect();
        exp_q.push_back(32'h40);
        settle();
        chk("br_target_pc", pc, 32'h40);

        // branch and jump together: jump wins
        cyc();
        br = 1'b1; br_tgt = 32'h80; jmp = 1'b1; j_tgt = 32'hC0;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'h44);
`endif
        cyc();
        settle();
        chk("both_pc", pc, 32'hC0);

        // same with stall: nothing moves, no flush
        stall = 1'b1;
        settle();
        chk("stall_flush", {31'd0, flush}, 32'd0);
        chk("stall_valid", {31'd0, fvalid}, 32'd0);
        cyc();
        settle();
        chk("stall_pc", pc, 32'hC0);
        stall = 1'b0;
        no_redirect();
        exp_q.push_back(32'hC0);

        // redirect to 0x100 while waiting, ready two cycles later
        cyc();
        ready = 1'b0;
        cyc();
        jmp = 1'b1; j_tgt = 32'h100;
        settle();
        chk("wait_redir_pc", pc, 32'hC4);
`ifndef BRANCH_DELAY_SLOT_EN
        chk("wait_redir_flush", {31'd0, flush}, 32'd1);
`endif
        cyc();
        no_redirect();
        settle();
        chk("redir_hold_pc", pc, 32'hC4);
        chk("redir_req", {31'd0, req}, 32'd1);
        cyc();
        ready = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'hC4);
`else
        settle();
        chk("redir_drop_valid", {31'd0, fvalid}, 32'd0);
        chk("redir_drop_flush", {31'd0, flush}, 32'd1);
`endif
        cyc();
        exp_q.push_back(32'h100);
        settle();
        chk("redir_target_pc", pc, 32'h100);

        // misaligned target 0x103
        cyc();
        jmp = 1'b1; j_tgt = 32'h103;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'h104);
`endif
        settle();
        chk("misalign_before", {31'd0, misalign}, 32'd0);
        cyc();
        j_tgt = 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_q.push_back(32'h100);
`endif
        settle();
        chk("misalign_pc", pc, 32'h100);
        chk("misalign_set", {31'd0, misalign}, 32'd1);

        // wrap at top of address space
        cyc();
        no_redirect();
        exp_q.push_back(32'hFFFF_FFFC);
        settle();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("misalign_sticky", {31'd0, misalign}, 32'd1);
        cyc();
        ready = 1'b0;
        settle();
        chk("wrap_pc", pc, 32'h0);

        // reset in the middle of a wait
        cyc();
        settle();
        chk("wait_before_rst_req", {31'd0, req}, 32'd1);
        rst_n = 1'b0;
        cyc();
        settle();
        chk("midrst_pc", pc, 32'hBFC0_0000);
        chk("midrst_req", {31'd0, req}, 32'd0);
        chk("midrst_misalign", {31'd0, misalign}, 32'd0);

        cyc(); cyc();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
